md5_msg_pad: RTL and testbench

MD5_MSG_PAD -- requirements
Module: md5_msg_pad

---
 rtl/md5_pkg.sv | 20 ++
 rtl/md5_pad_word.sv | 49 ++++
 rtl/md5_msg_pad.sv | 192 +++++++++++++++++++
 tb/tb_md5_msg_pad.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// ----------------------------------------------------------------------------
// md5_pkg
// Constants and types shared by the MD5 message padder and the MD5 round core.
//   BLOCK_BITS      : bits in one MD5 input block
//   WORDS_PER_BLOCK : 32-bit words in one block
//   LEN_BITS        : width of the trailing message-length field
//   pad_state_e     : IDLE/EMIT state encoding of the padder
// ----------------------------------------------------------------------------
package md5_pkg;

   localparam int BLOCK_BITS      = 512;
   localparam int WORDS_PER_BLOCK = 16;
   localparam int LEN_BITS        = 64;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } pad_state_e;

endpackage : md5_pkg

// File: rtl/md5_pad_word.sv
// ----------------------------------------------------------------------------
// md5_pad_word
// Combinational builder of one 32-bit word of a single-block padded MD5
// message. The message must already have every bit at index >= width cleared.
// Ports:
//   msg_i   [0:MAX_MSG_BITS-1] : message, bit 0 = MSB of the first byte
//   width_i [WID_W-1:0]        : message length in bits
//   idx_i   [3:0]              : word index inside the block (0..15)
//   word_o  [31:0]             : padded word, block byte 4*idx in [7:0]
// ----------------------------------------------------------------------------
module md5_pad_word
   import md5_pkg::*;
#(
   parameter int MAX_MSG_BITS = 128,
   parameter int WID_W        = $clog2(MAX_MSG_BITS + 1)
) (
   input  logic [0:MAX_MSG_BITS-1] msg_i,
   input  logic [WID_W-1:0]        width_i,
   input  logic [3:0]              idx_i,
   output logic [31:0]             word_o
);

   // Whole block, bit 0 = MSB of block byte 0 (MD5 byte stream order).
   logic [0:BLOCK_BITS-1] block_s;
   logic [LEN_BITS-1:0]   len_s;

   // Assemble message, pad bit and little-endian length field.
   always_comb begin
      block_s = '0;
      len_s   = LEN_BITS'(width_i);
      for (int p = 0; p < MAX_MSG_BITS; p++) begin
         block_s[p] = msg_i[p];
      end
      // Width never exceeds 447, so the pad bit always lands before byte 56.
      block_s[int'(width_i)] = 1'b1;
      for (int k = 0; k < LEN_BITS / 8; k++) begin
         block_s[(BLOCK_BITS - LEN_BITS) + k * 8 +: 8] = 8'(len_s >> (k * 8));
      end
   end

   // Pick four consecutive bytes; the lowest-addressed byte goes to [7:0].
   always_comb begin
      word_o = 32'h0000_0000;
      for (int b = 0; b < 4; b++) begin
         word_o[b * 8 +: 8] = block_s[(int'(idx_i) * 4 + b) * 8 +: 8];
      end
   end

endmodule : md5_pad_word

// File: rtl/md5_msg_pad.sv
// ----------------------------------------------------------------------------
// md5_msg_pad
// Accepts a message of up to MAX_MSG_BITS bits and streams the 16 words of
// its padded single MD5 block, word 0 first, with valid/ready handshaking.
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   msg_in            : message, bit 0 = MSB of the first byte
//   msg_in_width      : message length in bits (0..MAX_MSG_BITS legal)
//   msg_in_valid      : message strobe, taken only while ready=1
//   ready             : padder idle and able to take a message
//   word_out/word_idx : current padded word and its index
//   word_valid        : word_out/word_idx valid
//   word_ready        : downstream accepts the current word
//   word_last         : current word is word 15
//   width_err         : one-cycle pulse when an oversize message is rejected
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module md5_msg_pad
   import md5_pkg::*;
#(
   parameter  int MAX_MSG_BITS = 128,
   localparam int WID_W        = $clog2(MAX_MSG_BITS + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [0:MAX_MSG_BITS-1] msg_in,
   input  logic [0:WID_W-1]        msg_in_width,
   input  logic                    msg_in_valid,
   output logic                    ready,
   output logic [31:0]             word_out,
   output logic [3:0]              word_idx,
   output logic                    word_valid,
   input  logic                    word_ready,
   output logic                    word_last,
   output logic                    width_err
);

   pad_state_e              state_r, state_nx_s;
   logic [0:MAX_MSG_BITS-1] msg_r, masked_s, pw_msg_s;
   logic [WID_W-1:0]        width_r, pw_width_s;
   logic [3:0]              pw_idx_s;
   logic [31:0]             pw_word_s;
   logic                    width_ok_s, accept_s, hs_s, last_hs_s, load_s;
   logic                    ready_nx_s, word_valid_nx_s, word_last_nx_s, width_err_nx_s;
   logic [31:0]             word_out_nx_s;
   logic [3:0]              word_idx_nx_s;

   // Handshake qualifiers and input message masking.
   always_comb begin
      width_ok_s = (int'(msg_in_width) <= MAX_MSG_BITS);
      accept_s   = (state_r == ST_IDLE) && msg_in_valid && width_ok_s;
      hs_s       = word_valid && word_ready;
      last_hs_s  = hs_s && (word_idx == 4'd15);
      for (int p = 0; p < MAX_MSG_BITS; p++) begin
         masked_s[p] = msg_in[p] & (p < int'(msg_in_width));
      end
   end

   // The word builder prepares the word the output flops load next:
   // word 0 of the incoming message while idle, the following word otherwise.
   always_comb begin
      if (state_r == ST_IDLE) begin
         pw_msg_s   = masked_s;
         pw_width_s = msg_in_width;
         pw_idx_s   = 4'd0;
      end else begin
         pw_msg_s   = msg_r;
         pw_width_s = width_r;
         pw_idx_s   = word_idx + 4'd1;
      end
   end

   md5_pad_word #(
      .MAX_MSG_BITS (MAX_MSG_BITS),
      .WID_W        (WID_W)
   ) u_pad_word (
      .msg_i   (pw_msg_s),
      .width_i (pw_width_s),
      .idx_i   (pw_idx_s),
      .word_o  (pw_word_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nx_s = ST_EMIT;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_EMIT: begin
            if (last_hs_s) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_EMIT;
            end
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      word_valid_nx_s = word_valid;
      word_out_nx_s   = word_out;
      word_idx_nx_s   = word_idx;
      word_last_nx_s  = word_last;
      width_err_nx_s  = 1'b0;
      load_s          = 1'b0;
      ready_nx_s      = (state_nx_s == ST_IDLE);
      case (state_r)
         ST_IDLE: begin
            word_valid_nx_s = 1'b0;
            word_out_nx_s   = 32'h0000_0000;
            word_idx_nx_s   = 4'd0;
            word_last_nx_s  = 1'b0;
            if (accept_s) begin
               word_valid_nx_s = 1'b1;
               word_out_nx_s   = pw_word_s;
               load_s          = 1'b1;
            end else if (msg_in_valid) begin
               // Only reachable with an oversize width.
               width_err_nx_s = 1'b1;
            end else begin
               width_err_nx_s = 1'b0;
            end
         end
         ST_EMIT: begin
            if (last_hs_s) begin
               word_valid_nx_s = 1'b0;
               word_out_nx_s   = 32'h0000_0000;
               word_idx_nx_s   = 4'd0;
               word_last_nx_s  = 1'b0;
            end else if (hs_s) begin
               word_valid_nx_s = 1'b1;
               word_out_nx_s   = pw_word_s;
               word_idx_nx_s   = word_idx + 4'd1;
               word_last_nx_s  = (word_idx == 4'd14);
            end else begin
               word_valid_nx_s = word_valid;
            end
         end
         default: begin
            word_valid_nx_s = 1'b0;
            word_out_nx_s   = 32'h0000_0000;
            word_idx_nx_s   = 4'd0;
            word_last_nx_s  = 1'b0;
         end
      endcase
   end

   // Output flops and latched message.
   always_ff @(posedge clk) begin
      if (reset) begin
         ready      <= 1'b1;
         word_valid <= 1'b0;
         word_out   <= 32'h0000_0000;
         word_idx   <= 4'd0;
         word_last  <= 1'b0;
         width_err  <= 1'b0;
         msg_r      <= '0;
         width_r    <= '0;
      end else begin
         ready      <= ready_nx_s;
         word_valid <= word_valid_nx_s;
         word_out   <= word_out_nx_s;
         word_idx   <= word_idx_nx_s;
         word_last  <= word_last_nx_s;
         width_err  <= width_err_nx_s;
         if (load_s) begin
            msg_r   <= masked_s;
            width_r <= msg_in_width;
         end else begin
            msg_r   <= msg_r;
            width_r <= width_r;
         end
      end
   end

endmodule : md5_msg_pad

// File: tb/tb_md5_msg_pad.sv
// ----------------------------------------------------------------------------
// tb_md5_msg_pad
// Self-checking bench for md5_msg_pad: directed vectors (empty, "abc", masked
// 3-bit, full width, backpressure, oversize, reset mid-block) plus random
// messages, all compared with a byte-array model of the padded block.
// ----------------------------------------------------------------------------
module tb_md5_msg_pad;

   localparam int MAXB = 128;
   localparam int WW   = $clog2(MAXB + 1);

   logic            clk = 1'b0;
   logic            reset;
   logic [0:MAXB-1] msg_in;
   logic [0:WW-1]   msg_in_width;
   logic            msg_in_valid;
   logic            ready;
   logic [31:0]     word_out;
   logic [3:0]      word_idx;
   logic            word_valid;
   logic            word_ready;
   logic            word_last;
   logic            width_err;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] exp_w [16];

   md5_msg_pad #(.MAX_MSG_BITS(MAXB)) dut (
      .clk          (clk),
      .reset        (reset),
      .msg_in       (msg_in),
      .msg_in_width (msg_in_width),
      .msg_in_valid (msg_in_valid),
      .ready        (ready),
      .word_out     (word_out),
      .word_idx     (word_idx),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .word_last    (word_last),
      .width_err    (width_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Reference: build the 64-byte padded block, then slice little-endian words.
   task automatic model(input logic [0:MAXB-1] m, input int w);
      logic [7:0]  blk [64];
      logic [63:0] len;
      for (int k = 0; k < 64; k++) blk[k] = 8'h00;
      for (int p = 0; p < w; p++) begin
         if (m[p]) blk[p / 8] = blk[p / 8] | (8'h80 >> (p % 8));
      end
      blk[w / 8] = blk[w / 8] | (8'h80 >> (w % 8));
      len = 64'(w);
      for (int k = 0; k < 8; k++) blk[56 + k] = len[k * 8 +: 8];
      for (int i = 0; i < 16; i++) begin
         exp_w[i] = {blk[4 * i + 3], blk[4 * i + 2], blk[4 * i + 1], blk[4 * i]};
      end
   endtask

   task automatic send_msg(input logic [0:MAXB-1] m, input int w);
      msg_in       = m;
      msg_in_width = w[WW-1:0];
      msg_in_valid = 1'b1;
      @(negedge clk);
      msg_in_valid = 1'b0;
      msg_in       = '1;
   endtask

   // Send one message and consume its 16 words, stalling stall_len cycles at stall_at.
   task automatic run_block(input logic [0:MAXB-1] m, input int w, input int stall_at, input int stall_len);
      int got = 0;
      int stalled = 0;
      int budget = 0;
      model(m, w);
      word_ready = 1'b1;
      send_msg(m, w);
      chk("latency_valid", 32'(word_valid), 32'd1);
      while (got < 16 && budget < 200) begin
         if (word_valid) begin
            chk($sformatf("idx_w%0d", got), 32'(word_idx), 32'(got));
            chk($sformatf("word_w%0d", got), word_out, exp_w[got]);
            chk($sformatf("last_w%0d", got), 32'(word_last), 32'(got == 15));
            chk("ready_busy", 32'(ready), 32'd0);
            if (got == stall_at && stalled < stall_len) begin
               word_ready = 1'b0;
               stalled++;
            end else begin
               word_ready = 1'b1;
               got++;
            end
         end else begin
            word_ready = 1'b1;
         end
         @(negedge clk);
         budget++;
      end
      chk("block_words", 32'(got), 32'd16);
      chk("end_valid", 32'(word_valid), 32'd0);
      chk("end_ready", 32'(ready), 32'd1);
      chk("end_word", word_out, 32'h0);
   endtask

   initial begin
      logic [0:MAXB-1] m;
      int budget;
      reset        = 1'b1;
      msg_in       = '0;
      msg_in_width = '0;
      msg_in_valid = 1'b0;
      word_ready   = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_valid", 32'(word_valid), 32'd0);
      chk("rst_word", word_out, 32'h0);
      chk("rst_idx", 32'(word_idx), 32'd0);
      chk("rst_last", 32'(word_last), 32'd0);
      chk("rst_err", 32'(width_err), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Empty message.
      m = '0;
      run_block(m, 0, -1, 0);
      chk("empty_w0", exp_w[0], 32'h0000_0080);

      // "abc".
      m = '0;
      m[0:23] = 24'h616263;
      run_block(m, 24, -1, 0);
      chk("abc_w0", exp_w[0], 32'h8063_6261);
      chk("abc_w14", exp_w[14], 32'h0000_0018);

      // 3-bit message with all unused input bits set.
      m = '1;
      m[0:2] = 3'b101;
      run_block(m, 3, -1, 0);
      chk("b3_w0", exp_w[0], 32'h0000_00B0);
      chk("b3_w14", exp_w[14], 32'h0000_0003);

      // Backpressure: 5-cycle stall at word 3.
      m = '0;
      m[0:23] = 24'h616263;
      run_block(m, 24, 3, 5);

      // Full-width message.
      m = '1;
      run_block(m, MAXB, -1, 0);

      // Oversize width is rejected.
      msg_in       = '1;
      msg_in_width = WW'(MAXB + 1);
      msg_in_valid = 1'b1;
      @(negedge clk);
      msg_in_valid = 1'b0;
      chk("ovr_err", 32'(width_err), 32'd1);
      chk("ovr_valid", 32'(word_valid), 32'd0);
      chk("ovr_ready", 32'(ready), 32'd1);
      @(negedge clk);
      chk("ovr_err_pulse", 32'(width_err), 32'd0);
      chk("ovr_valid2", 32'(word_valid), 32'd0);
      chk("ovr_ready2", 32'(ready), 32'd1);

      // Reset at word 7, with a competing message and word_ready high.
      m = '0;
      m[0:23] = 24'h616263;
      word_ready = 1'b1;
      send_msg(m, 24);
      budget = 0;
      while (!(word_valid && word_idx == 4'd7) && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      chk("rstmid_reach7", 32'(word_idx), 32'd7);
      reset        = 1'b1;
      msg_in       = m;
      msg_in_width = WW'(24);
      msg_in_valid = 1'b1;
      @(negedge clk);
      reset        = 1'b0;
      msg_in_valid = 1'b0;
      chk("rstmid_valid", 32'(word_valid), 32'd0);
      chk("rstmid_ready", 32'(ready), 32'd1);
      chk("rstmid_word", word_out, 32'h0);
      @(negedge clk);
      chk("rstmid_idle", 32'(word_valid), 32'd0);
      run_block(m, 24, -1, 0);

      // Random messages, widths and stalls.
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < MAXB / 32; k++) m[k * 32 +: 32] = $urandom();
         run_block(m, int'($urandom_range(0, MAXB)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_md5_msg_pad
